ir_nec_cmd_decoder: RTL and testbench

Decodes NEC-protocol infrared remote frames from the IR receiver pin and turns them into the 3-bit drive command that feeds the JSON-over-UART transmitter. Directly upstream of that transmitter: its `state_control` output connects straight to the transmitter's `state_control` input. It measures pulse widths with a microsecond timebase, validates each frame, and maps command bytes to drive states.

---
 rtl/ir_nec_cmd_decoder_if.sv | 22 ++
 rtl/ir_nec_cmd_decoder.sv | 197 +++++++++++++++++++
 tb/tb_ir_nec_cmd_decoder.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_cmd_decoder_if.sv
// rtl/ir_nec_cmd_decoder_if.sv - IR receiver input and decoded command outputs of the NEC decoder
`timescale 1ns/1ps
interface ir_nec_cmd_decoder_if;
    logic       ir_in;
    logic [2:0] state_control;
    logic [7:0] cmd_code;
    logic [7:0] addr;
    logic       cmd_valid;
    logic       rep;
    logic       error;
    logic       busy;

    modport slave (
        input  ir_in,
        output state_control, cmd_code, addr, cmd_valid, rep, error, busy
    );

    modport master (
        output ir_in,
        input  state_control, cmd_code, addr, cmd_valid, rep, error, busy
    );
endinterface

// File: rtl/ir_nec_cmd_decoder.sv
// rtl/ir_nec_cmd_decoder.sv - NEC IR frame decoder producing 3-bit drive commands
`timescale 1ns/1ps
module ir_nec_cmd_decoder #(
    parameter int TICKS_PER_US = 50
) (
    input logic                 clk,
    input logic                 rst,
    ir_nec_cmd_decoder_if.slave ir_if
);
    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0] PSC_MAX    = PW'(TICKS_PER_US - 1);
    localparam logic [13:0]   US_MAX     = 14'd16383;
    localparam logic [13:0]   TIMEOUT_US = 14'd12000;

    typedef enum logic [2:0] {
        IDLE, LEADER, HDR_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_MARK
    } state_t;

    logic          sync1_q, sync2_q, prev_q;
    logic          ir_edge, ir_fall;
    logic [PW-1:0] psc_q;
    logic [13:0]   us_cnt_q;

    state_t        state_q, state_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic          last_ok_q, last_ok_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [2:0]    sc_q, sc_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          rep_q, rep_d;
    logic          error_q, error_d;
    logic          fail;

    // Synchronizer resets to the idle-high level so a quiet line produces no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= ir_if.ir_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign ir_edge = sync2_q ^ prev_q;
    assign ir_fall = prev_q & ~sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q    <= '0;
            us_cnt_q <= '0;
        end else if (ir_edge) begin
            psc_q    <= '0;
            us_cnt_q <= '0;
        end else if (psc_q == PSC_MAX) begin
            psc_q <= '0;
            if (us_cnt_q != US_MAX) us_cnt_q <= us_cnt_q + 14'd1;
        end else begin
            psc_q <= psc_q + 1'b1;
        end
    end

    function automatic logic in_win(input logic [13:0] v, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic w_leader, w_hdr, w_rep_hdr, w_short, w_long, frame_ok;
    assign w_leader  = in_win(us_cnt_q, 14'd8000, 14'd10000);
    assign w_hdr     = in_win(us_cnt_q, 14'd4000, 14'd5000);
    assign w_rep_hdr = in_win(us_cnt_q, 14'd2000, 14'd2500);
    assign w_short   = in_win(us_cnt_q, 14'd400,  14'd700);
    assign w_long    = in_win(us_cnt_q, 14'd1400, 14'd1900);
    assign frame_ok  = (shift_q[15:8] == ~shift_q[7:0]) && (shift_q[31:24] == ~shift_q[23:16]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            last_ok_q   <= 1'b0;
            addr_q      <= '0;
            cmd_q       <= '0;
            sc_q        <= 3'b000;
            cmd_valid_q <= 1'b0;
            rep_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            last_ok_q   <= last_ok_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            sc_q        <= sc_d;
            cmd_valid_q <= cmd_valid_d;
            rep_q       <= rep_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        last_ok_d   = last_ok_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        sc_d        = sc_q;
        cmd_valid_d = 1'b0;
        rep_d       = 1'b0;
        error_d     = 1'b0;
        fail        = 1'b0;
        case (state_q)
            IDLE: if (ir_fall) state_d = LEADER;
            LEADER: if (ir_edge) begin
                if (w_leader) state_d = HDR_SPACE;
                else          fail = 1'b1;
            end
            HDR_SPACE: if (ir_edge) begin
                if (w_hdr) begin
                    bit_cnt_d = '0;
                    state_d   = BIT_MARK;
                end else if (w_rep_hdr) begin
                    state_d = REP_MARK;
                end else begin
                    fail = 1'b1;
                end
            end
            BIT_MARK: if (ir_edge) begin
                if (w_short) state_d = BIT_SPACE;
                else         fail = 1'b1;
            end
            BIT_SPACE: if (ir_edge) begin
                if (w_short || w_long) begin
                    shift_d   = {w_long, shift_q[31:1]};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = (bit_cnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
                end else begin
                    fail = 1'b1;
                end
            end
            STOP_MARK: if (ir_edge) begin
                if (!w_short) begin
                    fail = 1'b1;
                end else begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        addr_d      = shift_q[7:0];
                        cmd_d       = shift_q[23:16];
                        cmd_valid_d = 1'b1;
                        last_ok_d   = 1'b1;
                        case (shift_q[23:16])
                            8'h44:   sc_d = 3'b001;
                            8'h43:   sc_d = 3'b010;
                            8'h46:   sc_d = 3'b011;
                            8'h15:   sc_d = 3'b100;
                            8'h40:   sc_d = 3'b000;
                            default: sc_d = sc_q;
                        endcase
                    end else begin
                        error_d   = 1'b1;
                        last_ok_d = 1'b0;
                    end
                end
            end
            REP_MARK: if (ir_edge) begin
                if (!w_short) begin
                    fail = 1'b1;
                end else begin
                    state_d = IDLE;
                    rep_d   = last_ok_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // A line stuck in one level mid-frame is treated like any other broken frame.
        if ((state_q != IDLE) && !ir_edge && (us_cnt_q >= TIMEOUT_US)) fail = 1'b1;
        if (fail) begin
            error_d   = 1'b1;
            last_ok_d = 1'b0;
            state_d   = IDLE;
        end
    end

    assign ir_if.state_control = sc_q;
    assign ir_if.cmd_code      = cmd_q;
    assign ir_if.addr          = addr_q;
    assign ir_if.cmd_valid     = cmd_valid_q;
    assign ir_if.rep           = rep_q;
    assign ir_if.error         = error_q;
    assign ir_if.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ir_nec_cmd_decoder.sv
// tb/tb_ir_nec_cmd_decoder.sv - randomized-timing self-checking bench for the NEC command decoder
`timescale 1ns/1ps
module tb_ir_nec_cmd_decoder;
    localparam int TPU = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ir_nec_cmd_decoder_if bus();
    ir_nec_cmd_decoder #(.TICKS_PER_US(TPU)) dut (.clk(clk), .rst(rst), .ir_if(bus));

    int checks = 0;
    int errors = 0;

    int     cnt_valid = 0, cnt_rep = 0, cnt_err = 0, viol = 0;
    longint cyc = 0, err_cyc = 0;
    logic   pv = 1'b0, pr = 1'b0, pe = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.cmd_valid) cnt_valid++;
        if (bus.rep) cnt_rep++;
        if (bus.error) begin cnt_err++; err_cyc = cyc; end
        if (int'(bus.cmd_valid) + int'(bus.rep) + int'(bus.error) > 1) viol++;
        if ((bus.cmd_valid && pv) || (bus.rep && pr) || (bus.error && pe)) viol++;
        pv = bus.cmd_valid; pr = bus.rep; pe = bus.error;
    end

    int         exp_valid = 0, exp_rep = 0, exp_err = 0;
    logic [2:0] m_sc = 3'b000;
    logic [7:0] m_cmd = 8'h00, m_addr = 8'h00;
    bit         m_ok = 1'b0;

    function automatic logic [2:0] map_cmd(input logic [7:0] c, input logic [2:0] cur);
        case (c)
            8'h44:   return 3'b001;
            8'h43:   return 3'b010;
            8'h46:   return 3'b011;
            8'h15:   return 3'b100;
            8'h40:   return 3'b000;
            default: return cur;
        endcase
    endfunction

    function automatic int rr(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    task automatic model_frame(input logic [7:0] a, na, c, nc);
        if (na == ~a && nc == ~c) begin
            exp_valid++; m_addr = a; m_cmd = c; m_sc = map_cmd(c, m_sc); m_ok = 1'b1;
        end else begin
            exp_err++; m_ok = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_sc = 3'b000; m_cmd = 8'h00; m_addr = 8'h00; m_ok = 1'b0;
    endtask

    task automatic drive(input logic lvl, input int us);
        #1 bus.ir_in = lvl;
        repeat (us * TPU) @(posedge clk);
    endtask

    task automatic send_body(input logic [7:0] a, na, c, nc, input int nbits);
        logic [31:0] w;
        w = {nc, c, na, a};
        drive(1'b0, rr(8100, 9900));
        drive(1'b1, rr(4100, 4900));
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, rr(450, 650));
            drive(1'b1, w[i] ? rr(1450, 1850) : rr(450, 650));
        end
    endtask

    task automatic send_frame(input logic [7:0] a, na, c, nc);
        send_body(a, na, c, nc, 32);
        drive(1'b0, rr(450, 650));
        drive(1'b1, 300);
        model_frame(a, na, c, nc);
    endtask

    task automatic send_repeat();
        drive(1'b0, rr(8100, 9900));
        drive(1'b1, rr(2050, 2450));
        drive(1'b0, rr(450, 650));
        drive(1'b1, 300);
        if (m_ok) exp_rep++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ir_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.state_control, bus.cmd_code, bus.addr} !== 19'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {bus.state_control, bus.cmd_code, bus.addr});
        end
        checks++;
        if ({bus.cmd_valid, bus.rep, bus.error, bus.busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.cmd_valid, bus.rep, bus.error, bus.busy});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_valid_left();
        logic v_early, b_early;
        send_body(8'h00, 8'hFF, 8'h44, 8'hBB, 32);
        drive(1'b0, 560);
        #1 bus.ir_in = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        v_early = bus.cmd_valid; b_early = bus.busy;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({v_early, b_early} !== 2'b01) begin
            errors++; $display("FAIL left_latency_early: got valid/busy %b expected 01", {v_early, b_early});
        end
        checks++;
        if ({bus.cmd_valid, bus.busy, bus.state_control} !== 5'b10001) begin
            errors++; $display("FAIL left_latency_edge3: got valid/busy/sc %b expected 10001", {bus.cmd_valid, bus.busy, bus.state_control});
        end
        drive(1'b1, 300);
        model_frame(8'h00, 8'hFF, 8'h44, 8'hBB);
        checks++;
        if ({bus.addr, bus.cmd_code, bus.state_control} !== {m_addr, m_cmd, m_sc}) begin
            errors++; $display("FAIL left_outputs: got %h expected %h", {bus.addr, bus.cmd_code, bus.state_control}, {m_addr, m_cmd, m_sc});
        end
        checks++;
        if (cnt_valid !== exp_valid || cnt_err !== exp_err) begin
            errors++; $display("FAIL left_counts: got valid %0d err %0d expected %0d %0d", cnt_valid, cnt_err, exp_valid, exp_err);
        end
    endtask

    task automatic test_cmd_sequence();
        logic [7:0] codes [4];
        logic [2:0] want  [4];
        logic [7:0] a;
        codes = '{8'h46, 8'h15, 8'h40, 8'h07};
        want  = '{3'b011, 3'b100, 3'b000, 3'b000};
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            send_frame(a, ~a, codes[i], ~codes[i]);
            checks++;
            if (bus.state_control !== want[i] || bus.state_control !== m_sc) begin
                errors++; $display("FAIL seq_sc_%0d: got %b expected %b", i, bus.state_control, want[i]);
            end
        end
        checks++;
        if (bus.cmd_code !== 8'h07 || bus.addr !== m_addr) begin
            errors++; $display("FAIL seq_cmd: got %h/%h expected 07/%h", bus.cmd_code, bus.addr, m_addr);
        end
        checks++;
        if (cnt_valid !== exp_valid) begin
            errors++; $display("FAIL seq_valid_count: got %0d expected %0d", cnt_valid, exp_valid);
        end
    endtask

    task automatic test_integrity();
        send_frame(8'h00, 8'hFF, 8'h44, 8'hBA);
        checks++;
        if (cnt_err !== exp_err || cnt_valid !== exp_valid) begin
            errors++; $display("FAIL integ_counts: got err %0d valid %0d expected %0d %0d", cnt_err, cnt_valid, exp_err, exp_valid);
        end
        checks++;
        if ({bus.state_control, bus.cmd_code} !== {m_sc, m_cmd}) begin
            errors++; $display("FAIL integ_hold: got %h expected %h", {bus.state_control, bus.cmd_code}, {m_sc, m_cmd});
        end
        send_repeat();
        checks++;
        if (cnt_rep !== exp_rep) begin
            errors++; $display("FAIL integ_no_rep: got %0d expected %0d", cnt_rep, exp_rep);
        end
    endtask

    task automatic test_repeat();
        send_frame(8'h10, 8'hEF, 8'h43, 8'hBC);
        send_repeat();
        checks++;
        if (cnt_rep !== exp_rep || cnt_valid !== exp_valid) begin
            errors++; $display("FAIL rep_counts: got rep %0d valid %0d expected %0d %0d", cnt_rep, cnt_valid, exp_rep, exp_valid);
        end
        checks++;
        if (bus.state_control !== 3'b010) begin
            errors++; $display("FAIL rep_sc: got %b expected 010", bus.state_control);
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        send_repeat();
        checks++;
        if (cnt_rep !== exp_rep || cnt_err !== exp_err || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rep_after_reset: got rep %0d err %0d busy %b expected %0d %0d 0", cnt_rep, cnt_err, bus.busy, exp_rep, exp_err);
        end
    endtask

    task automatic test_window();
        drive(1'b0, 7000);
        drive(1'b1, 300);
        exp_err++; m_ok = 1'b0;
        checks++;
        if (cnt_err !== exp_err || bus.busy !== 1'b0) begin
            errors++; $display("FAIL win_leader: got err %0d busy %b expected %0d 0", cnt_err, bus.busy, exp_err);
        end
        send_body(8'h00, 8'hFF, 8'h46, 8'hB9, 3);
        drive(1'b0, 560);
        drive(1'b1, 1000);
        drive(1'b0, 560);
        drive(1'b1, 500);
        exp_err++; m_ok = 1'b0;
        checks++;
        if (cnt_err !== exp_err || cnt_valid !== exp_valid) begin
            errors++; $display("FAIL win_space: got err %0d valid %0d expected %0d %0d", cnt_err, cnt_valid, exp_err, exp_valid);
        end
        send_frame(8'h00, 8'hFF, 8'h46, 8'hB9);
        checks++;
        if (bus.state_control !== 3'b011) begin
            errors++; $display("FAIL win_recover: got %b expected 011", bus.state_control);
        end
    endtask

    task automatic test_timeout();
        longint t0;
        #1 bus.ir_in = 1'b0;
        t0 = cyc;
        repeat (13000 * TPU) @(posedge clk);
        drive(1'b1, 300);
        exp_err++; m_ok = 1'b0;
        checks++;
        if (cnt_err !== exp_err || bus.busy !== 1'b0) begin
            errors++; $display("FAIL timeout_err: got err %0d busy %b expected %0d 0", cnt_err, bus.busy, exp_err);
        end
        checks++;
        if ((err_cyc - t0) < longint'(12000 * TPU) || (err_cyc - t0) > longint'(12002 * TPU + 4)) begin
            errors++; $display("FAIL timeout_time: got %0d cycles expected about %0d", err_cyc - t0, 12000 * TPU);
        end
    endtask

    task automatic test_reset_midframe();
        send_body(8'h00, 8'hFF, 8'h44, 8'hBB, 16);
        drive(1'b0, 560);
        drive(1'b1, 100);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.state_control, bus.cmd_code, bus.addr, bus.cmd_valid, bus.rep, bus.error, bus.busy} !== 23'h0) begin
            errors++; $display("FAIL midreset_values: got %h expected 0", {bus.state_control, bus.cmd_code, bus.addr, bus.busy});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive(1'b1, 500);
        checks++;
        if (cnt_err !== exp_err || bus.busy !== 1'b0) begin
            errors++; $display("FAIL midreset_no_err: got err %0d busy %b expected %0d 0", cnt_err, bus.busy, exp_err);
        end
        send_frame(8'h00, 8'hFF, 8'h44, 8'hBB);
        checks++;
        if (bus.state_control !== 3'b001 || cnt_valid !== exp_valid) begin
            errors++; $display("FAIL midreset_next: got sc %b valid %0d expected 001 %0d", bus.state_control, cnt_valid, exp_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [6];
        logic [7:0] a, c, nc;
        pool = '{8'h44, 8'h43, 8'h46, 8'h15, 8'h40, 8'h99};
        for (int i = 0; i < 3; i++) begin
            a  = 8'($urandom);
            c  = pool[rr(0, 5)];
            nc = (rr(0, 3) == 0) ? (~c ^ (8'h01 << rr(0, 7))) : ~c;
            send_frame(a, ~a, c, nc);
            if (rr(0, 1) == 1) send_repeat();
            checks++;
            if ({bus.addr, bus.cmd_code, bus.state_control} !== {m_addr, m_cmd, m_sc}) begin
                errors++; $display("FAIL rand_outputs_%0d: got %h expected %h", i, {bus.addr, bus.cmd_code, bus.state_control}, {m_addr, m_cmd, m_sc});
            end
            checks++;
            if (cnt_valid !== exp_valid || cnt_err !== exp_err || cnt_rep !== exp_rep) begin
                errors++; $display("FAIL rand_counts_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i, cnt_valid, cnt_err, cnt_rep, exp_valid, exp_err, exp_rep);
            end
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL pulse_shape: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_valid_left();
        test_cmd_sequence();
        test_integrity();
        test_repeat();
        test_window();
        test_timeout();
        test_reset_midframe();
        test_random();
        test_pulse_shape();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
